// File: rtl/tick_serial_tx.sv
// Tick-paced serial transmitter: start bit, DATA_W data bits LSB first, stop bit.
// Each bit is held for one tick interval; words arrive over a valid/ready handshake.
module tick_serial_tx #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_tx;
  logic              w_tx_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic [DATA_W-1:0] r_shreg;
  logic [DATA_W-1:0] w_shreg_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
      r_shreg <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tx    <= w_tx_nxt;
      r_done  <= w_done_nxt;
      r_shreg <= w_shreg_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Everything holds unless a tick arrives; done is a single-cycle pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = r_tx;
    w_done_nxt  = 1'b0;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_shreg_nxt = in_data;
          w_state_nxt = S_ALIGN;
        end
      end
      S_ALIGN: begin
        if (tick) begin
          w_tx_nxt    = 1'b0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          w_tx_nxt    = r_shreg[0];
          w_shreg_nxt = r_shreg >> 1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (r_cnt == CNT_LAST) begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = S_STOP;
          end else begin
            w_tx_nxt    = r_shreg[0];
            w_shreg_nxt = r_shreg >> 1;
            w_cnt_nxt   = r_cnt + CNT_W'(1);
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_tx_nxt    = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign in_ready = (r_state == S_IDLE);
  assign busy     = (r_state != S_IDLE);
  assign tx       = r_tx;
  assign done     = r_done;

endmodule

// File: tb/tb_tick_serial_tx.sv
// Bench for tick_serial_tx: tick-count frame model checked every cycle,
// plus directed frames with literal expected bit sequences.
module tb_tick_serial_tx;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          tick = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          tx;
  logic          busy;
  logic          done;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  tick_serial_tx #(.DATA_W(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .tx       (tx),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Tick source: 0 off, 1 tied high, 2 periodic (t_per), 3 random.
  int t_mode = 0;
  int t_per  = 3;
  int t_ph   = 0;
  always @(negedge clk) begin
    #1;
    case (t_mode)
      0: tick = 1'b0;
      1: tick = 1'b1;
      2: begin
        t_ph = (t_ph + 1) % t_per;
        tick = (t_ph == 0);
      end
      default: tick = ($urandom_range(0, 1) == 1);
    endcase
  end

  // Model: after acceptance, the k-th tick puts frame bit k-1 on the line
  // (frame = 0, data LSB first, 1); tick DATA_W+3 ends the frame with done.
  bit            m_busy = 1'b0;
  int            m_k    = 0;
  logic [DW-1:0] m_word = '0;
  logic          m_tx   = 1'b1;
  logic          m_done = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0;
      m_k    = 0;
      m_tx   = 1'b1;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (in_valid) begin
          m_busy = 1'b1;
          m_word = in_data;
          m_k    = 0;
        end
      end else if (tick) begin
        m_k++;
        if (m_k == DW + 3) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_tx   = 1'b1;
        end else if (m_k == 1) m_tx = 1'b0;
        else if (m_k <= DW + 1) m_tx = m_word[m_k-2];
        else m_tx = 1'b1;
      end
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_tx", tx, m_tx);
      chk("model_busy", busy, m_busy);
      chk("model_in_ready", in_ready, !m_busy);
      chk("model_done", done, m_done);
    end
  end

  task automatic wait_done(input int maxc, input string name);
    int c = 0;
    while (done !== 1'b1 && c < maxc) begin
      @(negedge clk);
      c++;
    end
    chk(name, done, 1);
  endtask

  task automatic wait_tx_low(input int maxc, input string name);
    int c = 0;
    while (tx !== 1'b0 && c < maxc) begin
      @(negedge clk);
      c++;
    end
    chk(name, tx, 0);
  endtask

  logic [9:0] exp_a = 10'b1001111000;  // 0x3C framed, index 0 first on line
  logic [9:0] exp_b = 10'b1101001010;  // 0xA5 framed, index 0 first on line

  initial begin
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    cmp_en = 1'b1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", in_ready, 1);

    // Tick tied high, 0x3C
    @(negedge clk);
    t_mode = 1; in_valid = 1'b1; in_data = 8'h3C;
    @(negedge clk);
    in_valid = 1'b0; in_data = 8'hFF;
    chk("A_align_tx", tx, 1);
    chk("A_busy", busy, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("A_bit", tx, exp_a[i]);
      chk("A_no_early_done", done, 0);
    end
    @(negedge clk);
    chk("A_done_at_11", done, 1);
    chk("A_ready_with_done", in_ready, 1);
    t_mode = 0;
    @(negedge clk);
    chk("A_done_one_cycle", done, 0);

    // Divide-by-3 ticks, 0xA5: each line value held 3 cycles
    @(negedge clk);
    t_mode = 2; t_per = 3; t_ph = 0; in_valid = 1'b1; in_data = 8'hA5;
    @(negedge clk);
    in_valid = 1'b0;
    chk("B_busy", busy, 1);
    wait_tx_low(10, "B_start_seen");
    for (int b = 0; b < 10; b++) begin
      for (int j = 0; j < 3; j++) begin
        if (b != 0 || j != 0) @(negedge clk);
        chk("B_bit", tx, exp_b[b]);
        chk("B_no_early_done", done, 0);
      end
    end
    @(negedge clk);
    chk("B_done", done, 1);
    @(negedge clk);
    chk("B_done_one_cycle", done, 0);

    // Back-to-back with in_valid held; data change mid-frame is ignored
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h01;
    @(negedge clk);
    chk("C_busy1", busy, 1);
    in_data = 8'hFF;
    begin
      int c = 0;
      while (done !== 1'b1 && c < 60) begin
        @(negedge clk);
        if (done !== 1'b1) chk("C_ready_low", in_ready, 0);
        c++;
      end
    end
    chk("C_done1", done, 1);
    chk("C_ready_at_done", in_ready, 1);
    @(negedge clk);
    chk("C_accept_in_done_cycle", busy, 1);
    in_valid = 1'b0; in_data = 8'h00;
    wait_done(60, "C_done2");

    // Tick stall after acceptance of 0x55
    @(negedge clk);
    t_mode = 0; in_valid = 1'b1; in_data = 8'h55;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      chk("D_stall_tx", tx, 1);
      chk("D_stall_busy", busy, 1);
    end
    t_mode = 2; t_per = 3; t_ph = 0;
    wait_done(60, "D_done");

    // Tick in IDLE and on acceptance; start bit lasts one full interval (P=4)
    @(negedge clk);
    t_mode = 1;
    repeat (3) begin
      @(negedge clk);
      chk("E_idle_tx", tx, 1);
    end
    in_valid = 1'b1; in_data = 8'h93;
    @(negedge clk);
    in_valid = 1'b0; t_mode = 0;
    repeat (5) begin
      @(negedge clk);
      chk("E_hold_tx", tx, 1);
      chk("E_hold_busy", busy, 1);
    end
    t_mode = 2; t_per = 4; t_ph = 0;
    wait_tx_low(10, "E_start_seen");
    begin
      int n = 0;
      while (tx === 1'b0 && n < 20) begin
        n++;
        @(negedge clk);
      end
      chk("E_start_len", n, 4);
    end
    wait_done(80, "E_done");

    // Reset mid-frame while data bit 3 is on the line
    @(negedge clk);
    t_mode = 2; t_per = 3; t_ph = 0; in_valid = 1'b1; in_data = 8'h5A;
    @(negedge clk);
    in_valid = 1'b0;
    wait_tx_low(10, "R_start_seen");
    repeat (13) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("R_tx", tx, 1);
    chk("R_busy", busy, 0);
    chk("R_done", done, 0);
    chk("R_ready", in_ready, 1);
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk("R_quiet_tx", tx, 1);
      chk("R_quiet_busy", busy, 0);
    end

    // Random traffic, tick patterns and occasional resets
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (i % 250 == 0) begin
        t_mode = $urandom_range(2, 3);
        t_per  = $urandom_range(1, 4);
        t_ph   = 0;
      end
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = DW'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        #2 reset = 1'b1;
        #4 reset = 1'b0;
      end
    end

    in_valid = 1'b0;
    t_mode   = 1;
    repeat (30) @(negedge clk);
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/tick_serial_tx.md
# tick_serial_tx

Tick-paced serial transmitter that consumes the one-cycle-in-three enable pulse from the divide-by-3 FSM and shifts a parallel word out on a single line. The frame format is one start bit (0), DATA_W data bits LSB first, and one stop bit (1). Each bit lasts exactly one tick interval. Upstream logic hands words in over a valid/ready handshake; the tick source is an input, so any enable pattern is supported, including tick tied high.

## Interface
- DATA_W, 8, payload width in bits (≥1)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; forces all state to reset values immediately
- tick  in  1  bit-rate enable, one clk wide; normally the divide-by-3 FSM output y
- in_valid  in  1  upstream word present
- in_data  in  DATA_W  word to send; sampled only at acceptance
- in_ready  out  1  block can accept; high iff state is IDLE
- tx  out  1  serial line, registered, idle high
- busy  out  1  high iff state is not IDLE
- done  out  1  one-cycle pulse at frame end

## Operation
- Reset values: state=IDLE, tx=1, busy=0, done=0, in_ready=1, bit counter=0, shift register=0.
- Acceptance: a clk edge with in_valid=1 and in_ready=1.
  - in_data is loaded into the shift register.
  - state goes to ALIGN.
  - tx is unchanged (1).
- States (all transitions on a clk edge, gated by tick except where stated):
  - IDLE: tick is ignored. On acceptance → ALIGN (no tick needed).
  - ALIGN: tx=1. On tick → START, tx←0. This aligns the start bit to a full tick interval.
  - START: on tick → DATA, tx←shreg[0], shreg shifts right by 1, cnt←0.
  - DATA: on tick with cnt<DATA_W-1 → tx←shreg[0], shift, cnt←cnt+1. On tick with cnt==DATA_W-1 → STOP, tx←1.
  - STOP: on tick → IDLE, done←1 for exactly one cycle.
- Without a tick, every state holds and all registers keep their values.
- in_data and in_valid changes while busy are ignored.
- Back-to-back frames: in_ready is high in the cycle done=1. A word accepted in that cycle enters ALIGN with no idle gap beyond alignment.
- Reset mid-frame: tx goes to 1 and busy/done go to 0 asynchronously. The partial word is discarded and nothing resumes after reset release.
- Counter width: clog2(DATA_W), minimum 1 bit. cnt never exceeds DATA_W-1.

## Timing
- With tick every cycle, from the acceptance edge E0:
  - E1: tx=0
  - E2..E(DATA_W+1): data bits
  - E(DATA_W+2): tx=1 (stop bit)
  - E(DATA_W+3): done=1, IDLE
  - For DATA_W=8, done asserts 11 cycles after acceptance.
- With a tick period of P cycles: start, data and stop bits each last exactly P cycles. ALIGN lasts 1..P cycles depending on tick phase.
- The divide-by-3 source gives P=3, so a frame is (DATA_W+2)·3 cycles plus ALIGN.
- done rises on the same edge that returns the state to IDLE, so in_ready and done are both high in that cycle.
- A tick coincident with acceptance is not used. ALIGN waits for the next tick.

## Test plan
- Reset: drive reset=1 during a frame (tick every 3 cycles, data bit 3 on line) → tx=1, busy=0, done=0, in_ready=1 immediately. After release with no in_valid, tx stays 1 for 20 cycles.
- Nominal, tick from divide-by-3 FSM (P=3), send 0xA5 → tx holds 0,1,0,1,0,0,1,0,1,1 (start, bits LSB first, stop), each value for 3 cycles. done pulses once, 1 cycle wide.
- Tick tied high, send 0x3C → tx after acceptance edge reads 0,0,0,1,1,1,1,0,0,1. done occurs 11 cycles after acceptance.
- Back-to-back: in_valid held high with 0x01 then 0xFF → in_ready low throughout frame 1. 0xFF is accepted in the done cycle. in_data changed mid-frame has no effect on tx.
- Tick stall: tick held 0 after acceptance of 0x55 → state stays ALIGN, tx=1, busy=1 indefinitely. Resuming ticks completes the correct frame.
- Tick in IDLE and on the acceptance cycle → no tx change before the first tick after acceptance. The start bit still lasts one full tick interval.
